// File: rtl/fu_matrix_ls_seq.sv
// Sequenced matrix load/store unit: expands one matrix LD/ST into ROWS row requests,
// bounds requests in flight to MAX_OUT, and pulses done once every row has completed.
module fu_matrix_ls_seq #(
  parameter int ADDR_W  = 32,
  parameter int MD_W    = 4,
  parameter int ROWS    = 4,
  parameter int MAX_OUT = 2,
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic [MD_W-1:0]   in_md,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_imm,
  input  logic [ADDR_W-1:0] in_stride,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_write,
  output logic [MD_W-1:0]   mem_req_md,
  output logic [ROW_W-1:0]  mem_req_row,
  input  logic              mem_resp_valid,
  output logic              busy,
  output logic              done,
  output logic [MD_W-1:0]   done_md,
  output logic [1:0]        dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends combinationally on ready, and request payload holds while valid & !ready.
  localparam int ISS_W = $clog2(ROWS + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [ISS_W-1:0] ROWS_C    = ISS_W'(ROWS);
  localparam logic [ISS_W-1:0] LAST_C    = ISS_W'(ROWS - 1);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [MD_W-1:0]     md_q;
  logic                write_q;
  logic [ADDR_W-1:0]   stride_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ISS_W-1:0]    iss_q;
  logic [ISS_W-1:0]    comp_q;
  logic [OUT_W-1:0]    out_q;
  logic                req_hs;
  logic                resp_acc;

  assign req_hs = mem_req_valid && mem_req_ready;
  // Responses outside ISSUE/DRAIN or with nothing outstanding are strays and are dropped.
  assign resp_acc = mem_resp_valid && (out_q != '0) &&
                    ((state_q == S_ISSUE) || (state_q == S_DRAIN));

  assign mem_req_addr  = addr_q;
  assign mem_req_write = write_q;
  assign mem_req_md    = md_q;
  assign mem_req_row   = iss_q[ROW_W-1:0];
  assign busy          = (state_q != S_IDLE);
  assign dbg_state     = state_q;

  always_comb begin
    state_d       = state_q;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    done          = 1'b0;
    done_md       = '0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mem_req_valid = (out_q < MAX_OUT_C);
        if (mem_req_valid && mem_req_ready && (iss_q == LAST_C)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((comp_q + ISS_W'(resp_acc)) == ROWS_C) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        done_md = md_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      md_q     <= '0;
      write_q  <= 1'b0;
      stride_q <= '0;
      addr_q   <= '0;
      iss_q    <= '0;
      comp_q   <= '0;
      out_q    <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && in_valid) begin
        md_q     <= in_md;
        write_q  <= !in_load;
        stride_q <= in_stride;
        addr_q   <= in_base + in_imm;
        iss_q    <= '0;
        comp_q   <= '0;
        out_q    <= '0;
      end else begin
        if (req_hs) begin
          iss_q  <= iss_q + ISS_W'(1);
          addr_q <= addr_q + stride_q;
        end
        if (resp_acc) comp_q <= comp_q + ISS_W'(1);
        case ({req_hs, resp_acc})
          2'b10:   out_q <= out_q + OUT_W'(1);
          2'b01:   out_q <= out_q - OUT_W'(1);
          default: out_q <= out_q;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fu_matrix_ls_seq.sv
// Bench for fu_matrix_ls_seq: randomized instructions and memory timing checked against
// a queue-based model of the row requests, in-flight count and done timing.
`timescale 1ns/1ps
module tb_fu_matrix_ls_seq;
  localparam int ADDR_W  = 32;
  localparam int MD_W    = 4;
  localparam int ROWS    = 4;
  localparam int MAX_OUT = 2;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int W       = 1 + MD_W + ROW_W + ADDR_W;

  // clock / reset
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_load = 1'b0;
  logic [MD_W-1:0]   in_md = '0;
  logic [ADDR_W-1:0] in_base = '0, in_imm = '0, in_stride = '0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_write;
  logic [MD_W-1:0]   mem_req_md;
  logic [ROW_W-1:0]  mem_req_row;
  logic              mem_resp_valid = 1'b0;
  logic              busy, done;
  logic [MD_W-1:0]   done_md;
  logic [1:0]        dbg_state;

  fu_matrix_ls_seq #(.ADDR_W(ADDR_W), .MD_W(MD_W), .ROWS(ROWS), .MAX_OUT(MAX_OUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_md(in_md),
    .in_base(in_base), .in_imm(in_imm), .in_stride(in_stride),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
    .mem_req_md(mem_req_md), .mem_req_row(mem_req_row),
    .mem_resp_valid(mem_resp_valid), .busy(busy), .done(done), .done_md(done_md),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_fail = 0;

  // reference model state
  logic [W-1:0]    exp_q[$];
  bit              active = 0;
  bit              done_exp = 0;
  int              pend = 0, rcnt = 0, hs_cnt = 0, done_cnt = 0, acc_cnt = 0;
  int              done_cyc = 0, acc_cyc = 0;
  logic [MD_W-1:0] cur_md = '0;

  // memory-side behaviour knobs
  int              ready_mode = 0;   // 0 always ready, 1 random
  int              resp_mode = 0;    // 0 respond asap, 1 random, 2 withhold
  bit              force_resp = 0;
  logic [ROW_W-1:0] stall_row = '0;
  int              stall_left = 0;

  // Scoreboard: checks every cycle on the falling edge, then advances the model.
  always @(negedge CLK) begin
    logic [W-1:0] obs;
    bit acc, rsp, hs, exp_v;
    if (!nRST) begin
      active = 0; done_exp = 0; pend = 0; rcnt = 0; hs_cnt = 0;
      exp_q.delete();
    end else begin
      acc   = in_valid && !active;
      exp_v = active && (exp_q.size() > 0) && (pend < MAX_OUT);
      n_vec++;
      if (in_ready !== !active) begin
        n_fail++; $display("FAIL in_ready cyc=%0d: got %b want %b", cyc, in_ready, !active);
      end
      n_vec++;
      if (busy !== active) begin
        n_fail++; $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, active);
      end
      n_vec++;
      if (mem_req_valid !== exp_v) begin
        n_fail++; $display("FAIL req_valid cyc=%0d: got %b want %b", cyc, mem_req_valid, exp_v);
      end
      if (mem_req_valid === 1'b1 && exp_q.size() > 0) begin
        obs = {mem_req_write, mem_req_md, mem_req_row, mem_req_addr};
        n_vec++;
        if (obs !== exp_q[0]) begin
          n_fail++; $display("FAIL req_payload cyc=%0d: got %h want %h", cyc, obs, exp_q[0]);
        end
      end
      n_vec++;
      if (done !== done_exp) begin
        n_fail++; $display("FAIL done cyc=%0d: got %b want %b", cyc, done, done_exp);
      end
      if (done === 1'b1) begin
        n_vec++;
        if (done_md !== cur_md) begin
          n_fail++; $display("FAIL done_md cyc=%0d: got %h want %h", cyc, done_md, cur_md);
        end
        n_vec++;
        if (hs_cnt != ROWS || exp_q.size() != 0) begin
          n_fail++; $display("FAIL row_count cyc=%0d: got %0d want %0d", cyc, hs_cnt, ROWS);
        end
      end
      hs  = (mem_req_valid === 1'b1) && mem_req_ready && (exp_q.size() > 0);
      rsp = mem_resp_valid && active && (pend > 0);
      done_exp = 0;
      if (rsp) begin
        pend--; rcnt++;
        if (rcnt == ROWS) done_exp = 1;
      end
      if (hs) begin
        void'(exp_q.pop_front());
        hs_cnt++; pend++;
      end
      if (done === 1'b1) begin
        active = 0; done_cnt++; done_cyc = cyc;
      end
      if (acc) begin
        active = 1; rcnt = 0; hs_cnt = 0; pend = 0; acc_cnt++;
        cur_md = in_md;
        for (int r = 0; r < ROWS; r++)
          exp_q.push_back({!in_load, in_md, ROW_W'(r),
                           ADDR_W'(in_base + in_imm + ADDR_W'(r) * in_stride)});
      end
    end
  end

  // Memory responder: drives ready/response a little after each rising edge.
  always @(posedge CLK) begin
    logic r;
    #2;
    r = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    if (mem_req_valid && mem_req_row == stall_row && stall_left > 0) begin
      r = 1'b0; stall_left--;
    end
    mem_req_ready  = r;
    mem_resp_valid = force_resp ||
      ((pend > 0) && (resp_mode == 0 || (resp_mode == 1 && $urandom_range(0, 1) == 1)));
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input bit ld, input logic [MD_W-1:0] md,
                      input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] i,
                      input logic [ADDR_W-1:0] s);
    int t = 0;
    while (in_ready !== 1'b1 && t < 100) begin step(1); t++; end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL send_timeout: in_ready got %b want 1", in_ready);
    end
    in_valid = 1'b1; in_load = ld; in_md = md; in_base = b; in_imm = i; in_stride = s;
    acc_cyc = cyc;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget);
    int t = 0;
    while (done_cnt == prev && t < budget) begin step(1); t++; end
    n_vec++;
    if (done_cnt != prev + 1) begin
      n_fail++; $display("FAIL wait_done: done count got %0d want %0d", done_cnt, prev + 1);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    step(2);
    n_vec++;
    if ({in_ready, busy, mem_req_valid, done} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 1000", {in_ready, busy, mem_req_valid, done});
    end
    n_vec++;
    if ({mem_req_addr, mem_req_write, mem_req_md, mem_req_row, done_md, dbg_state} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h w=%b md=%h row=%h dmd=%h st=%h want 0",
                         mem_req_addr, mem_req_write, mem_req_md, mem_req_row, done_md, dbg_state);
    end
    nRST = 1'b1;
    step(1);
  endtask

  task automatic test_load_basic();
    int prev = done_cnt;
    ready_mode = 0; resp_mode = 0;
    send(1'b1, 4'd3, 32'h1000, 32'h10, 32'h40);
    wait_done(prev, 50);
    n_vec++;
    if (done_cyc - acc_cyc != ROWS + 2) begin
      n_fail++; $display("FAIL done_latency: got %0d want %0d", done_cyc - acc_cyc, ROWS + 2);
    end
    step(1);
  endtask

  task automatic test_store_stall();
    int prev = done_cnt;
    ready_mode = 0; resp_mode = 0;
    stall_row = ROW_W'(1); stall_left = 3;
    send(1'b0, 4'd5, 32'h2000, 32'h4, 32'h100);
    wait_done(prev, 50);
    n_vec++;
    if (stall_left != 0) begin
      n_fail++; $display("FAIL stall_applied: left got %0d want 0", stall_left);
    end
    step(2);
    n_vec++;
    if (done_cnt != prev + 1) begin
      n_fail++; $display("FAIL single_done: got %0d want %0d", done_cnt - prev, 1);
    end
  endtask

  task automatic test_max_out();
    int prev = done_cnt;
    ready_mode = 0; resp_mode = 2;
    send(1'b1, 4'd9, $urandom, $urandom, $urandom);
    step(8);
    n_vec++;
    if (hs_cnt != MAX_OUT || mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL max_out: got hs=%0d valid=%b want hs=%0d valid=0",
                         hs_cnt, mem_req_valid, MAX_OUT);
    end
    resp_mode = 0;
    step(1);
    n_vec++;
    if (mem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL max_out_release: valid got %b want 1", mem_req_valid);
    end
    wait_done(prev, 50);
    step(1);
  endtask

  task automatic test_wrap_stride0();
    int prev = done_cnt;
    ready_mode = 0; resp_mode = 0;
    send(1'b1, 4'd7, 32'hFFFF_FFF0, 32'h0, 32'h10);
    wait_done(prev, 50);
    step(1);
    prev = done_cnt;
    send(1'b0, 4'd2, $urandom, $urandom, 32'h0);
    wait_done(prev, 50);
    step(1);
  endtask

  task automatic test_reset_in_drain();
    int prev = done_cnt;
    int t = 0;
    ready_mode = 0; resp_mode = 0;
    send(1'b1, 4'd12, 32'h3000, 32'h0, 32'h20);
    while (hs_cnt < ROWS && t < 50) begin step(1); t++; end
    resp_mode = 2;
    step(1);
    n_vec++;
    if (dbg_state !== 2'd2 || busy !== 1'b1) begin
      n_fail++; $display("FAIL drain_reached: state got %0d busy %b want 2 busy 1", dbg_state, busy);
    end
    nRST = 1'b0;
    step(1);
    nRST = 1'b1;
    n_vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got rdy=%b busy=%b done=%b want 1 0 0", in_ready, busy, done);
    end
    force_resp = 1'b1;
    step(1);
    force_resp = 1'b0;
    resp_mode = 0;
    step(2);
    n_vec++;
    if (done_cnt != prev || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL stray_resp: got dones=%0d state=%0d want 0 dones state 0",
                         done_cnt - prev, dbg_state);
    end
    prev = done_cnt;
    send(1'b1, 4'd4, $urandom, $urandom, $urandom);
    wait_done(prev, 50);
    step(1);
  endtask

  task automatic test_back_to_back();
    int prev_d = done_cnt;
    int prev_a = acc_cnt;
    int t = 0;
    ready_mode = 1; resp_mode = 1;
    in_valid = 1'b1;
    while (done_cnt < prev_d + 3 && t < 400) begin
      in_load = 1'($urandom); in_md = MD_W'($urandom);
      in_base = $urandom; in_imm = $urandom; in_stride = $urandom;
      step(1); t++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (done_cnt != prev_d + 3 || acc_cnt != prev_a + 3) begin
      n_fail++; $display("FAIL back_to_back: got dones=%0d accepts=%0d want 3 3",
                         done_cnt - prev_d, acc_cnt - prev_a);
    end
    step(1);
  endtask

  task automatic test_random();
    int prev;
    ready_mode = 1; resp_mode = 1;
    for (int k = 0; k < 12; k++) begin
      prev = done_cnt;
      send(1'($urandom), MD_W'($urandom), $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      wait_done(prev, 300);
      step($urandom_range(0, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_store_stall();
    test_max_out();
    test_wrap_stride0();
    test_reset_in_drain();
    test_back_to_back();
    test_random();
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
